// File: rtl/mem_access_ctrl.sv
// Initiator for the data-memory strobe interface: sequences address setup,
// trigger pulse and recovery per request, and returns a valid/ready response.
module mem_access_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_readAddr,
  output logic [ADDR_W-1:0] mem_writeAddr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_trigRead,
  output logic              mem_trigWrite,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       is_write;

  // NOTE: every registered signal uses non-blocking assignment so all updates
  // in this block see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      is_write      <= 1'b0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      mem_readAddr  <= '0;
      mem_writeAddr <= '0;
      mem_writeData <= '0;
      mem_trigRead  <= 1'b0;
      mem_trigWrite <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_write   <= req_write;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (req_addr[1:0] != 2'b00) begin
              // Misaligned: answer immediately, memory is never touched.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state <= S_SETUP;
              if (req_write) begin
                mem_writeAddr <= req_addr[ADDR_W+1:2];
                mem_writeData <= req_wdata;
              end else begin
                mem_readAddr <= req_addr[ADDR_W+1:2];
              end
            end
          end
        end

        S_SETUP: begin
          state <= S_STROBE;
          cnt   <= '0;
          if (is_write) mem_trigWrite <= 1'b1;
          else          mem_trigRead  <= 1'b1;
        end

        S_STROBE: begin
          if (cnt == PULSE_LAST) begin
            // Memory has sampled on the rising edge; its data is stable here.
            mem_trigRead  <= 1'b0;
            mem_trigWrite <= 1'b0;
            if (!is_write) resp_rdata <= mem_readData;
            cnt   <= '0;
            state <= S_RECOVER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_RECOVER: begin
          if (cnt == GAP_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: default-timing instance plus a
// PULSE_CYCLES=1 / GAP_CYCLES=3 instance, each with a small memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 (defaults)
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, trig_r, trig_w;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [6:0]  raddr, waddr;

  // Instance 2 (short pulse, long gap)
  logic        req_valid2 = 1'b0, req_write2 = 1'b0, resp_ready2 = 1'b1;
  logic [8:0]  req_addr2 = '0;
  logic [31:0] req_wdata2 = '0;
  logic        req_ready2, resp_valid2, resp_err2, trig_r2, trig_w2;
  logic [31:0] resp_rdata2, mem_wdata2, mem_rdata2;
  logic [6:0]  raddr2, waddr2;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_readAddr(raddr), .mem_writeAddr(waddr), .mem_writeData(mem_wdata),
    .mem_trigRead(trig_r), .mem_trigWrite(trig_w), .mem_readData(mem_rdata)
  );

  mem_access_ctrl #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_readAddr(raddr2), .mem_writeAddr(waddr2), .mem_writeData(mem_wdata2),
    .mem_trigRead(trig_r2), .mem_trigWrite(trig_w2), .mem_readData(mem_rdata2)
  );

  // Memory models: sample on the rising edge of the strobes.
  logic [31:0] mem1 [128];
  logic [31:0] mem2 [128];
  int rise_r = 0, rise_w = 0;
  always @(posedge trig_w)  begin mem1[waddr] = mem_wdata; rise_w++; end
  always @(posedge trig_r)  begin mem_rdata = mem1[raddr]; rise_r++; end
  always @(posedge trig_w2) mem2[waddr2] = mem_wdata2;
  always @(posedge trig_r2) mem_rdata2 = mem2[raddr2];

  // Pulse width / spacing monitor for instance 2.
  int pulses2 = 0, cur_w = 0, max_w = 0, low_run = 0, min_gap = 1000;
  logic in_pulse = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (trig_r2 || trig_w2) begin
        if (!in_pulse) begin
          if (pulses2 > 0 && low_run < min_gap) min_gap = low_run;
          pulses2++;
        end
        cur_w++;
        in_pulse = 1'b1;
        low_run  = 0;
      end else begin
        if (in_pulse && cur_w > max_w) max_w = cur_w;
        if (in_pulse) cur_w = 0;
        in_pulse = 1'b0;
        low_run++;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("no_dual_trig", {31'd0, trig_r & trig_w}, 32'd0);
  endtask

  task automatic send(input logic wr, input logic [8:0] addr, input logic [31:0] wd);
    check("req_ready_before_send", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp2();
    int n = 0;
    while (!resp_valid2 && n < 20) begin step(); n++; end
    check("resp2_timeout", {31'd0, resp_valid2}, 32'd1);
  endtask

  int rr, rw;

  initial begin
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_trigs", {30'd0, trig_r, trig_w}, 32'd0);
    check("rst_addrs", {18'd0, raddr, waddr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);

    // Store DEADBEEF to word 4; cycle T+1 is now.
    send(1'b1, 9'h010, 32'hDEADBEEF);
    check("st_waddr", {25'd0, waddr}, 32'd4);
    check("st_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_setup_trigs", {30'd0, trig_r, trig_w}, 32'd0);
    check("st_req_ready", {31'd0, req_ready}, 32'd0);
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("st_trig_w_T%0d", c), {31'd0, trig_w}, (c == 2 || c == 3) ? 32'd1 : 32'd0);
      check($sformatf("st_trig_r_T%0d", c), {31'd0, trig_r}, 32'd0);
      check($sformatf("st_waddr_T%0d", c), {25'd0, waddr}, 32'd4);
      check($sformatf("st_resp_valid_T%0d", c), {31'd0, resp_valid}, (c == 5) ? 32'd1 : 32'd0);
    end
    check("st_resp_err", {31'd0, resp_err}, 32'd0);
    check("st_resp_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("st_done_valid", {31'd0, resp_valid}, 32'd0);
    check("st_done_ready", {31'd0, req_ready}, 32'd1);

    // Load word 4 back.
    send(1'b0, 9'h010, 32'h0);
    check("ld_raddr", {25'd0, raddr}, 32'd4);
    check("ld_waddr_held", {25'd0, waddr}, 32'd4);
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("ld_trig_r_T%0d", c), {31'd0, trig_r}, (c == 2 || c == 3) ? 32'd1 : 32'd0);
      check($sformatf("ld_trig_w_T%0d", c), {31'd0, trig_w}, 32'd0);
      check($sformatf("ld_resp_valid_T%0d", c), {31'd0, resp_valid}, (c == 5) ? 32'd1 : 32'd0);
    end
    check("ld_rdata", resp_rdata, 32'hDEADBEEF);
    check("ld_err", {31'd0, resp_err}, 32'd0);

    // Backpressure for 10 cycles while an extra request is offered.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_no_extra_write", rise_w, 32'd1);
    check("bp_read_count", rise_r, 32'd1);

    // Misaligned load: immediate error response, no strobe.
    rr = rise_r; rw = rise_w;
    send(1'b0, 9'h013, 32'h0);
    check("mis_valid", {31'd0, resp_valid}, 32'd1);
    check("mis_err", {31'd0, resp_err}, 32'd1);
    check("mis_rdata", resp_rdata, 32'd0);
    check("mis_trigs", {30'd0, trig_r, trig_w}, 32'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("mis_done_valid", {31'd0, resp_valid}, 32'd0);
    check("mis_done_err", {31'd0, resp_err}, 32'd0);
    step();
    check("mis_no_trig", rise_r + rise_w, rr + rw);

    // Second instance: back-to-back store/load at word 127.
    req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 9'h1FC; req_wdata2 = 32'hFFFFFFFF;
    step();
    req_valid2 = 1'b0;
    check("b2b_waddr", {25'd0, waddr2}, 32'd127);
    wait_resp2();
    check("b2b_st_err", {31'd0, resp_err2}, 32'd0);
    step();
    check("b2b_ready", {31'd0, req_ready2}, 32'd1);
    req_valid2 = 1'b1; req_write2 = 1'b0;
    step();
    req_valid2 = 1'b0;
    check("b2b_raddr", {25'd0, raddr2}, 32'd127);
    wait_resp2();
    check("b2b_ld_rdata", resp_rdata2, 32'hFFFFFFFF);
    step(); step();
    check("b2b_pulses", pulses2, 32'd2);
    check("b2b_width", max_w, 32'd1);
    check("b2b_gap_ge4", {31'd0, min_gap >= 4}, 32'd1);

    // Reset during the first strobe cycle of a load.
    send(1'b0, 9'h010, 32'h0);
    step();
    check("rst_mid_trig_high", {31'd0, trig_r}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_trig_async", {30'd0, trig_r, trig_w}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
      check("post_rst_trigs", {30'd0, trig_r, trig_w}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the data-memory strobe interface. Accepts one load/store request at a time from the CPU datapath. Converts each request into a correctly sequenced address setup, trigger strobe and recovery on the memory's trigRead/trigWrite pins. Returns read data or completion to the datapath through a valid/ready response channel.

Parameters:
ADDR_W, 7, memory word-address width (mem_readAddr/mem_writeAddr)
DATA_W, 32, data word width
PULSE_CYCLES, 2, clock cycles a trigger is held high (legal range 1..15)
GAP_CYCLES, 1, minimum cycles both triggers stay low after a strobe (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W+2  byte address; [1:0] must be 00
req_wdata  in  DATA_W  store data
resp_valid  out  1  response present
resp_ready  in  1  datapath accepts the response
resp_rdata  out  DATA_W  load data (0 for stores and errors)
resp_err  out  1  misaligned request, no memory access made
mem_readAddr  out  ADDR_W  memory read word address
mem_writeAddr  out  ADDR_W  memory write word address
mem_writeData  out  DATA_W  memory write data
mem_trigRead  out  1  read strobe; memory samples on its rising edge
mem_trigWrite  out  1  write strobe; memory samples on its rising edge
mem_readData  in  DATA_W  memory read data

Behaviour:
- All outputs are registered. Reset (asynchronous, immediate) sets state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, both triggers=0, and all addresses and write data=0.
- States: IDLE, SETUP, STROBE, RECOVER, RESP.
- IDLE: req_ready=1. On req_valid, the controller latches write, req_addr[ADDR_W+1:2] and wdata.
  - If req_addr[1:0]!=0, go to RESP with resp_err=1 and resp_rdata=0. No trigger is raised.
  - Otherwise, go to SETUP.
- req_ready is 0 in every state except IDLE.
- SETUP: lasts 1 cycle. Drive the word address on mem_readAddr (load) or mem_writeAddr (store), and drive mem_writeData for stores. Both triggers are 0. The idle address port holds its previous value.
- STROBE: lasts exactly PULSE_CYCLES cycles, counted by a 4-bit counter.
  - mem_trigRead=1 for a load; mem_trigWrite=1 for a store; never both.
  - Address and data are held stable for the whole strobe.
- STROBE to RECOVER: on the clock edge that leaves STROBE, both triggers drop to 0. For a load, mem_readData is captured into resp_rdata on that same edge.
- RECOVER: lasts GAP_CYCLES cycles with both triggers 0 and address and data held. Then go to RESP.
- RESP: resp_valid=1. resp_rdata and resp_err are held until resp_valid && resp_ready. Then resp_valid=0, resp_err=0, and the state returns to IDLE.
- Timing with defaults, request accepted at edge T:
  - SETUP is cycle T+1.
  - Triggers are high in cycles T+2 and T+3.
  - RECOVER is cycle T+4.
  - resp_valid rises in cycle T+5.
  - Minimum accept-to-response is 3+PULSE_CYCLES+GAP_CYCLES-2 = 4 edges.
- Back-to-back requests: req_ready returns the cycle after the response handshake. Consecutive strobes are always separated by at least GAP_CYCLES+1 low cycles (RECOVER plus SETUP).
- Invariant: mem_trigRead && mem_trigWrite is never 1.
- Invariant: a trigger only rises from SETUP→STROBE and only falls STROBE→RECOVER, so there are no glitches and no mid-strobe address change.
- Reset mid-STROBE: triggers drop at once and any pending response is discarded. A store whose trigger already rose may have been committed by memory; this is permitted.
- resp_ready held high before resp_valid has no effect. req_valid is ignored outside IDLE.

Test Plan:
- Store req_addr=0x010 (word 4), wdata=0xDEADBEEF -> mem_writeAddr=4 in T+1; mem_trigWrite high exactly T+2..T+3; mem_trigRead stays 0; resp_valid in T+5 with resp_err=0, resp_rdata=0.
- Load from word 4 after the store, with the memory model attached -> mem_trigRead high 2 cycles; resp_rdata=0xDEADBEEF; mem_trigWrite stays 0 throughout.
- Misaligned load req_addr=0x013 -> no trigger ever asserts; resp_valid one cycle after accept with resp_err=1, resp_rdata=0.
- Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid and resp_rdata stable, req_ready=0, a new req_valid is ignored. Release -> req_ready=1 next cycle.
- Back-to-back store word 127 (0xFFFFFFFF) then load word 127 with PULSE_CYCLES=1, GAP_CYCLES=3 -> strobes are 1 cycle wide and separated by ≥4 low cycles; load returns 0xFFFFFFFF.
- Assert rst_n=0 in the first STROBE cycle of a load -> triggers go 0 asynchronously (same cycle); after release, req_ready=1, resp_valid=0, and no stale response appears.
